// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and widths for the master-side arbiter and related blocks.
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant: round-robin against last_grant, or fixed priority to requester 0.
module rr_arbiter2 #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: gnt = (FIXED_PRIORITY || last_grant) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// AXI4-Lite 2:1 arbiter: one read or write transaction downstream at a time,
// owner picked in IDLE and held until its response handshake completes.
module axi_lite_arbiter
    import axi_lite_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    // master 0 (IFU)
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    input  logic [AXI_ADDR_W-1:0] m0_araddr,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    output logic [AXI_DATA_W-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    input  logic                  m0_awvalid,
    output logic                  m0_awready,
    input  logic [AXI_ADDR_W-1:0] m0_awaddr,
    input  logic                  m0_wvalid,
    output logic                  m0_wready,
    input  logic [AXI_DATA_W-1:0] m0_wdata,
    input  logic [AXI_STRB_W-1:0] m0_wmask,
    output logic                  m0_bvalid,
    input  logic                  m0_bready,
    output logic [1:0]            m0_bresp,
    // master 1 (LSU)
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    input  logic [AXI_ADDR_W-1:0] m1_araddr,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [AXI_DATA_W-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [AXI_ADDR_W-1:0] m1_awaddr,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    input  logic [AXI_DATA_W-1:0] m1_wdata,
    input  logic [AXI_STRB_W-1:0] m1_wmask,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    output logic [1:0]            m1_bresp,
    // downstream port
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [AXI_ADDR_W-1:0] s_araddr,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [AXI_DATA_W-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [AXI_ADDR_W-1:0] s_awaddr,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    output logic [AXI_DATA_W-1:0] s_wdata,
    output logic [AXI_STRB_W-1:0] s_wmask,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    input  logic [1:0]            s_bresp
);

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic [1:0] gnt;
    logic       aw_hs, w_hs;

    logic own_arvalid, own_rready, own_awvalid, own_wvalid, own_bready;
    logic own_arready, own_rvalid, own_awready, own_wready, own_bvalid;

    rr_arbiter2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_rr (
        .req        ({m1_arvalid | m1_awvalid | m1_wvalid,
                      m0_arvalid | m0_awvalid | m0_wvalid}),
        .last_grant (last_q),
        .gnt        (gnt)
    );

    assign own_arvalid = owner_q ? m1_arvalid : m0_arvalid;
    assign own_rready  = owner_q ? m1_rready  : m0_rready;
    assign own_awvalid = owner_q ? m1_awvalid : m0_awvalid;
    assign own_wvalid  = owner_q ? m1_wvalid  : m0_wvalid;
    assign own_bready  = owner_q ? m1_bready  : m0_bready;

    assign s_araddr = owner_q ? m1_araddr : m0_araddr;
    assign s_awaddr = owner_q ? m1_awaddr : m0_awaddr;
    assign s_wdata  = owner_q ? m1_wdata  : m0_wdata;
    assign s_wmask  = owner_q ? m1_wmask  : m0_wmask;

    // Response payload mirrors s on both sides; only the owner ever sees a valid.
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m1_rresp = s_rresp;
    assign m0_bresp = s_bresp;
    assign m1_bresp = s_bresp;

    assign m0_arready = own_arready & ~owner_q;
    assign m1_arready = own_arready &  owner_q;
    assign m0_rvalid  = own_rvalid  & ~owner_q;
    assign m1_rvalid  = own_rvalid  &  owner_q;
    assign m0_awready = own_awready & ~owner_q;
    assign m1_awready = own_awready &  owner_q;
    assign m0_wready  = own_wready  & ~owner_q;
    assign m1_wready  = own_wready  &  owner_q;
    assign m0_bvalid  = own_bvalid  & ~owner_q;
    assign m1_bvalid  = own_bvalid  &  owner_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        s_awvalid   = 1'b0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        own_arready = 1'b0;
        own_rvalid  = 1'b0;
        own_awready = 1'b0;
        own_wready  = 1'b0;
        own_bvalid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    owner_d = gnt[1];
                    state_d = (gnt[1] ? m1_arvalid : m0_arvalid) ? ST_RD_ADDR : ST_WR_REQ;
                end
            end
            ST_RD_ADDR: begin
                s_arvalid   = own_arvalid;
                own_arready = s_arready;
                if (own_arvalid && s_arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                own_rvalid = s_rvalid;
                s_rready   = own_rready;
                if (s_rvalid && own_rready) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end
            end
            ST_WR_REQ: begin
                s_awvalid   = own_awvalid & ~aw_done_q;
                s_wvalid    = own_wvalid  & ~w_done_q;
                own_awready = s_awready   & ~aw_done_q;
                own_wready  = s_wready    & ~w_done_q;
                aw_hs       = own_awvalid & s_awready & ~aw_done_q;
                w_hs        = own_wvalid  & s_wready  & ~w_done_q;
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                own_bvalid = s_bvalid;
                s_bready   = own_bready;
                if (s_bvalid && own_bready) begin
                    state_d   = ST_IDLE;
                    last_d    = owner_q;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench for axi_lite_arbiter: directed master traffic, a behavioural slave,
// and a negedge monitor that pops expected handshakes/responses as they appear.
module tb_axi_lite_arbiter;
    import axi_lite_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
    logic        m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic [31:0] m0_araddr, m0_rdata, m0_awaddr, m0_wdata;
    logic [3:0]  m0_wmask;
    logic [1:0]  m0_rresp, m0_bresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
    logic        m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [31:0] m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
    logic [3:0]  m1_wmask;
    logic [1:0]  m1_rresp, m1_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic        s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [3:0]  s_wmask;
    logic [1:0]  s_rresp, s_bresp;

    logic [1:0] rr_req;
    logic       rr_last;
    logic [1:0] gnt_rr, gnt_fp;

    axi_lite_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
        .clk(clk), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bresp(m0_bresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
    );

    rr_arbiter2 #(.FIXED_PRIORITY(1'b0)) u_rr (.req(rr_req), .last_grant(rr_last), .gnt(gnt_rr));
    rr_arbiter2 #(.FIXED_PRIORITY(1'b1)) u_fp (.req(rr_req), .last_grant(rr_last), .gnt(gnt_fp));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake (t=%0t)", name, $time);
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct { logic id; logic is_wr; logic [31:0] addr; } addr_t;
    typedef struct { logic id; logic [31:0] data; logic [3:0] mask; } w_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } r_t;

    addr_t      exp_addr[$];
    w_t         exp_w[$];
    r_t         exp_r0[$], exp_r1[$];
    logic [1:0] exp_b0[$], exp_b1[$];

    // ---------------- behavioural slave ----------------
    int         ar_delay = 0;
    int         r_delay  = 2;
    logic [1:0] slave_bresp = RESP_OKAY;

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'hDEAD_BEEF : ~a;
    endfunction

    function automatic logic [1:0] slave_rresp(input logic [31:0] a);
        return (a == 32'h0000_5000) ? RESP_DECERR : RESP_OKAY;
    endfunction

    initial begin
        logic        sl_rst, sl_arv, sl_ar_hs, sl_r_hs, sl_aw_hs, sl_w_hs, sl_b_hs;
        logic        r_pend, aw_got, w_got;
        logic [31:0] sl_addr, r_addr;
        int          ar_cnt, r_cnt;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
        r_pend = 0; aw_got = 0; w_got = 0; r_addr = 0; ar_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge clk);
            sl_rst   = reset;
            sl_arv   = s_arvalid;
            sl_ar_hs = s_arvalid && s_arready;
            sl_r_hs  = s_rvalid && s_rready;
            sl_aw_hs = s_awvalid && s_awready;
            sl_w_hs  = s_wvalid && s_wready;
            sl_b_hs  = s_bvalid && s_bready;
            sl_addr  = s_araddr;
            @(posedge clk);
            #1;
            if (sl_rst) begin
                s_arready = 0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;
                r_pend = 0; aw_got = 0; w_got = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                s_awready = 1;
                s_wready  = 1;
                if (sl_r_hs) s_rvalid = 0;
                if (sl_ar_hs) begin
                    s_arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0; r_addr = sl_addr;
                end else if (!r_pend && !s_rvalid) begin
                    if (ar_delay == 0) s_arready = 1;
                    else if (sl_arv) begin
                        if (ar_cnt >= ar_delay) s_arready = 1;
                        else ar_cnt++;
                    end
                end
                if (r_pend) begin
                    if (r_cnt >= r_delay) begin
                        s_rvalid = 1; s_rdata = slave_data(r_addr); s_rresp = slave_rresp(r_addr);
                        r_pend = 0;
                    end else r_cnt++;
                end
                if (sl_aw_hs) aw_got = 1;
                if (sl_w_hs)  w_got  = 1;
                if (sl_b_hs) s_bvalid = 0;
                else if (aw_got && w_got && !s_bvalid) begin
                    s_bvalid = 1; s_bresp = slave_bresp; aw_got = 0; w_got = 0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        addr_t       ea;
        w_t          ew;
        r_t          er;
        logic [1:0]  eb;
        logic        m0_any, m1_any;
        logic        ar_wait, r0_wait, r1_wait;
        logic [31:0] ar_prev, r0_prev, r1_prev;
        ar_wait = 0; r0_wait = 0; r1_wait = 0; ar_prev = 0; r0_prev = 0; r1_prev = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ar_wait = 0; r0_wait = 0; r1_wait = 0;
            end else begin
                if ((s_arvalid && s_arready) || (s_awvalid && s_awready)) begin
                    if (exp_addr.size() == 0) timeout("addr_phase_unexpected");
                    else begin
                        ea = exp_addr.pop_front();
                        check("addr_kind", 32'(s_awvalid && s_awready), 32'(ea.is_wr));
                        if (ea.is_wr) begin
                            check("aw_addr", s_awaddr, ea.addr);
                            check("aw_owner", 32'({m1_awready, m0_awready}), ea.id ? 32'd2 : 32'd1);
                        end else begin
                            check("ar_addr", s_araddr, ea.addr);
                            check("ar_owner", 32'({m1_arready, m0_arready}), ea.id ? 32'd2 : 32'd1);
                        end
                    end
                end
                if (s_wvalid && s_wready) begin
                    if (exp_w.size() == 0) timeout("w_unexpected");
                    else begin
                        ew = exp_w.pop_front();
                        check("w_data", s_wdata, ew.data);
                        check("w_mask", 32'(s_wmask), 32'(ew.mask));
                        check("w_owner", 32'({m1_wready, m0_wready}), ew.id ? 32'd2 : 32'd1);
                    end
                end
                if (m0_rvalid && m0_rready) begin
                    if (exp_r0.size() == 0) timeout("m0_r_unexpected");
                    else begin
                        er = exp_r0.pop_front();
                        check("m0_rdata", m0_rdata, er.data);
                        check("m0_rresp", 32'(m0_rresp), 32'(er.resp));
                    end
                end
                if (m1_rvalid && m1_rready) begin
                    if (exp_r1.size() == 0) timeout("m1_r_unexpected");
                    else begin
                        er = exp_r1.pop_front();
                        check("m1_rdata", m1_rdata, er.data);
                        check("m1_rresp", 32'(m1_rresp), 32'(er.resp));
                    end
                end
                if (m0_bvalid && m0_bready) begin
                    if (exp_b0.size() == 0) timeout("m0_b_unexpected");
                    else begin eb = exp_b0.pop_front(); check("m0_bresp", 32'(m0_bresp), 32'(eb)); end
                end
                if (m1_bvalid && m1_bready) begin
                    if (exp_b1.size() == 0) timeout("m1_b_unexpected");
                    else begin eb = exp_b1.pop_front(); check("m1_bresp", 32'(m1_bresp), 32'(eb)); end
                end
                m0_any = m0_arready | m0_awready | m0_wready | m0_rvalid | m0_bvalid;
                m1_any = m1_arready | m1_awready | m1_wready | m1_rvalid | m1_bvalid;
                if (m0_any || m1_any) check("one_master_active", 32'(m0_any & m1_any), 32'd0);
                if (ar_wait && s_arvalid) check("araddr_stable", s_araddr, ar_prev);
                if (r0_wait) begin
                    check("m0_rvalid_held", 32'(m0_rvalid), 32'd1);
                    check("m0_rdata_stable", m0_rdata, r0_prev);
                end
                if (r1_wait) begin
                    check("m1_rvalid_held", 32'(m1_rvalid), 32'd1);
                    check("m1_rdata_stable", m1_rdata, r1_prev);
                end
                ar_wait = s_arvalid && !s_arready; ar_prev = s_araddr;
                r0_wait = m0_rvalid && !m0_rready; r0_prev = m0_rdata;
                r1_wait = m1_rvalid && !m1_rready; r1_prev = m1_rdata;
            end
        end
    end

    // ---------------- master drivers ----------------
    task automatic set_ar(input logic id, input logic v, input logic [31:0] a);
        if (id) begin m1_arvalid = v; m1_araddr = a; end
        else    begin m0_arvalid = v; m0_araddr = a; end
    endtask
    task automatic set_rready(input logic id, input logic v);
        if (id) m1_rready = v; else m0_rready = v;
    endtask
    task automatic set_aw(input logic id, input logic v, input logic [31:0] a);
        if (id) begin m1_awvalid = v; m1_awaddr = a; end
        else    begin m0_awvalid = v; m0_awaddr = a; end
    endtask
    task automatic set_w(input logic id, input logic v, input logic [31:0] d, input logic [3:0] m);
        if (id) begin m1_wvalid = v; m1_wdata = d; m1_wmask = m; end
        else    begin m0_wvalid = v; m0_wdata = d; m0_wmask = m; end
    endtask
    task automatic set_bready(input logic id, input logic v);
        if (id) m1_bready = v; else m0_bready = v;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic m_read(input logic id, input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int rdy_delay);
        int n;
        if (id) exp_r1.push_back('{exp_data, exp_resp});
        else    exp_r0.push_back('{exp_data, exp_resp});
        set_ar(id, 1, addr);
        n = 0;
        do begin @(negedge clk); n++; end while (!(id ? m1_arready : m0_arready) && n < 300);
        if (n >= 300) timeout("read_ar");
        @(posedge clk); #1;
        set_ar(id, 0, addr);
        n = 0;
        do begin @(negedge clk); n++; end while (!(id ? m1_rvalid : m0_rvalid) && n < 300);
        if (n >= 300) timeout("read_r");
        repeat (rdy_delay) @(posedge clk);
        @(posedge clk); #1;
        set_rready(id, 1);
        @(posedge clk); #1;
        set_rready(id, 0);
    endtask

    task automatic m_write(input logic id, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input int w_lead, input logic [1:0] exp_resp);
        int   n;
        logic aw_d, w_d, awh, wh;
        exp_w.push_back('{id, data, mask});
        if (id) exp_b1.push_back(exp_resp); else exp_b0.push_back(exp_resp);
        set_w(id, 1, data, mask);
        if (w_lead == 0) set_aw(id, 1, addr);
        aw_d = 0; w_d = 0; n = 0;
        while (!(aw_d && w_d) && n < 300) begin
            @(negedge clk);
            awh = id ? (m1_awvalid && m1_awready) : (m0_awvalid && m0_awready);
            wh  = id ? (m1_wvalid && m1_wready)   : (m0_wvalid && m0_wready);
            @(posedge clk); #1;
            n++;
            if (awh) begin aw_d = 1; set_aw(id, 0, addr); end
            if (wh)  begin w_d = 1; set_w(id, 0, data, mask); end
            if (!aw_d && n == w_lead) set_aw(id, 1, addr);
        end
        if (!(aw_d && w_d)) timeout("write_aw_w");
        set_bready(id, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!(id ? m1_bvalid : m0_bvalid) && n < 300);
        if (n >= 300) timeout("write_b");
        @(posedge clk); #1;
        set_bready(id, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic check_quiet(input string name);
        check(name, 32'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                         m0_arready, m0_awready, m0_wready, m0_rvalid, m0_bvalid,
                         m1_arready, m1_awready, m1_wready, m1_rvalid, m1_bvalid}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [1:0] v_req  [5];
        logic       v_last [5];
        logic [1:0] v_rr   [5];
        logic [1:0] v_fp   [5];
        int         n;
        v_req  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        v_last = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
        v_rr   = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b01};
        v_fp   = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b01};

        m0_arvalid = 0; m0_araddr = 0; m0_rready = 0; m0_awvalid = 0; m0_awaddr = 0;
        m0_wvalid = 0; m0_wdata = 0; m0_wmask = 0; m0_bready = 0;
        m1_arvalid = 0; m1_araddr = 0; m1_rready = 0; m1_awvalid = 0; m1_awaddr = 0;
        m1_wvalid = 0; m1_wdata = 0; m1_wmask = 0; m1_bready = 0;
        rr_req = 0; rr_last = 0;

        for (int i = 0; i < 5; i++) begin
            rr_req = v_req[i]; rr_last = v_last[i];
            #1;
            check("rr_gnt", 32'(gnt_rr), 32'(v_rr[i]));
            check("fp_gnt", 32'(gnt_fp), 32'(v_fp[i]));
        end

        do_reset();
        @(negedge clk);
        check_quiet("reset_outputs");

        // 1: lone m0 read, one cycle of arbitration latency
        @(posedge clk); #1;
        exp_addr.push_back('{1'b0, 1'b0, 32'h8000_0000});
        fork
            m_read(1'b0, 32'h8000_0000, 32'hDEAD_BEEF, RESP_OKAY, 0);
            begin
                @(negedge clk);
                check("t1_s_arvalid_idle", 32'(s_arvalid), 32'd0);
                @(negedge clk);
                check("t1_s_arvalid_fwd", 32'(s_arvalid), 32'd1);
                check("t1_m1_quiet", 32'({m1_arready, m1_rvalid}), 32'd0);
            end
        join

        // 2: simultaneous m0 read and m1 write straight after reset
        do_reset();
        exp_addr.push_back('{1'b0, 1'b0, 32'h8000_0000});
        exp_addr.push_back('{1'b1, 1'b1, 32'hA000_03F8});
        fork
            m_read(1'b0, 32'h8000_0000, 32'hDEAD_BEEF, RESP_OKAY, 0);
            m_write(1'b1, 32'hA000_03F8, 32'h0000_0041, 4'b0001, 0, RESP_OKAY);
        join

        // 3: both masters reading back to back, round-robin alternates
        @(posedge clk); #1;
        exp_addr.push_back('{1'b0, 1'b0, 32'h0000_1000});
        exp_addr.push_back('{1'b1, 1'b0, 32'h0000_2000});
        exp_addr.push_back('{1'b0, 1'b0, 32'h0000_1004});
        exp_addr.push_back('{1'b1, 1'b0, 32'h0000_2004});
        fork
            begin
                m_read(1'b0, 32'h0000_1000, 32'hFFFF_EFFF, RESP_OKAY, 0);
                m_read(1'b0, 32'h0000_1004, 32'hFFFF_EFFB, RESP_OKAY, 0);
            end
            begin
                m_read(1'b1, 32'h0000_2000, 32'hFFFF_DFFF, RESP_OKAY, 0);
                m_read(1'b1, 32'h0000_2004, 32'hFFFF_DFFB, RESP_OKAY, 0);
            end
        join

        // 4: m1 writes, W leading AW by 3 cycles, then AW/W together; SLVERR passed through
        @(posedge clk); #1;
        slave_bresp = RESP_SLVERR;
        exp_addr.push_back('{1'b1, 1'b1, 32'h0000_6000});
        m_write(1'b1, 32'h0000_6000, 32'h1234_5678, 4'b1111, 3, RESP_SLVERR);
        exp_addr.push_back('{1'b1, 1'b1, 32'h0000_6004});
        m_write(1'b1, 32'h0000_6004, 32'hCAFE_F00D, 4'b0011, 0, RESP_SLVERR);
        slave_bresp = RESP_OKAY;

        // 5: back-pressure on AR and R while m1 waits
        @(posedge clk); #1;
        ar_delay = 5;
        exp_addr.push_back('{1'b0, 1'b0, 32'h0000_3000});
        exp_addr.push_back('{1'b1, 1'b0, 32'h0000_4000});
        fork
            m_read(1'b0, 32'h0000_3000, 32'hFFFF_CFFF, RESP_OKAY, 3);
            begin
                @(posedge clk); #1;
                m_read(1'b1, 32'h0000_4000, 32'hFFFF_BFFF, RESP_OKAY, 0);
            end
        join
        ar_delay = 0;

        // 6: reset while m0 has rvalid pending, then a clean m1 read
        @(posedge clk); #1;
        exp_addr.push_back('{1'b0, 1'b0, 32'h8000_0010});
        set_ar(1'b0, 1, 32'h8000_0010);
        n = 0;
        do begin @(negedge clk); n++; end while (!m0_arready && n < 300);
        if (n >= 300) timeout("t6_ar");
        @(posedge clk); #1;
        set_ar(1'b0, 0, 32'h8000_0010);
        n = 0;
        do begin @(negedge clk); n++; end while (!m0_rvalid && n < 300);
        if (n >= 300) timeout("t6_rvalid");
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check_quiet("t6_after_reset");
        @(posedge clk); #1;
        exp_addr.push_back('{1'b1, 1'b0, 32'h0000_5000});
        m_read(1'b1, 32'h0000_5000, 32'hFFFF_AFFF, RESP_DECERR, 0);

        repeat (5) @(posedge clk);
        check("left_addr", 32'(exp_addr.size()), 32'd0);
        check("left_w",    32'(exp_w.size()),    32'd0);
        check("left_r0",   32'(exp_r0.size()),   32'd0);
        check("left_r1",   32'(exp_r1.size()),   32'd0);
        check("left_b0",   32'(exp_b0.size()),   32'd0);
        check("left_b1",   32'(exp_b1.size()),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
AXI4-Lite 2-master-to-1-slave arbiter, the converging counterpart of the 1-to-2 address-decoding crossbar. Sits between IFU (m0) and LSU (m1) and the shared memory-side port (s); the port s typically feeds the crossbar. One transaction (read or write) is in flight downstream at a time. Arbitration is round-robin by default, or fixed m0 priority.

Parameters:
FIXED_PRIORITY, 0, 0 = round-robin between m0/m1; 1 = m0 always wins when both request.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
m0  axi_lite_if.slave  -  master 0 (IFU); araddr/awaddr 32, rdata/wdata 32, wmask 4, rresp/bresp 2
m1  axi_lite_if.slave  -  master 1 (LSU); same widths
s  axi_lite_if.master  -  downstream port to the crossbar/slave; same widths

Behaviour:
- Reset values: state IDLE; owner=m0; last_grant=m1, so m0 is preferred first; aw_done=w_done=0.
- Outputs in IDLE: all s.*valid, s.rready, s.bready and all m*.{arready,awready,wready,rvalid,bvalid} are 0.
- Request of master i: req_i = mi.arvalid | mi.awvalid | mi.wvalid. Kind: read if mi.arvalid, else write. A read wins over a write from the same master.
- Grant, IDLE only:
  - If no req, stay in IDLE.
  - If one req, grant it.
  - If both req: FIXED_PRIORITY=1 grants m0; otherwise grant the master other than last_grant.
  - Owner and kind are registered. Forwarding starts the next cycle, so arbitration adds 1 cycle of latency.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- RD_ADDR:
  - s.arvalid=own.arvalid, s.araddr=own.araddr, own.arready=s.arready.
  - On s.arvalid&&s.arready, go to RD_DATA.
- RD_DATA:
  - own.rvalid=s.rvalid, own.rdata=s.rdata, own.rresp=s.rresp, s.rready=own.rready.
  - On handshake, go to IDLE and set last_grant=owner.
- WR_REQ:
  - AW and W are forwarded independently: s.awvalid=own.awvalid&!aw_done and s.wvalid=own.wvalid&!w_done.
  - own.awready and own.wready are gated the same way.
  - aw_done/w_done are set on their handshakes. AW and W may complete in the same cycle or in either order.
  - When both are done (counting a handshake in the current cycle), go to WR_RESP.
- WR_RESP:
  - Forward the B channel.
  - On bvalid&&bready, go to IDLE, set last_grant=owner, clear aw_done/w_done.
- Non-owner master: all its ready and valid outputs are 0. Its rdata/rresp/bresp may mirror s, but are don't-care.
- Payload (addr/data/wmask) is muxed from owner, combinationally, in every non-IDLE state. In IDLE the s payload is don't-care, with valids 0.
- A master must hold valid/payload until its handshake (AXI rule). The arbiter never drops a granted request.
- Non-owner requests wait; no starvation. Under round-robin, with both masters continuously requesting, grants alternate strictly.
- Reset mid-transaction returns the block to IDLE with reset values. The downstream slave shares reset, so no orphan response is expected.
- No protocol error detection. Responses are passed through unmodified.

Decomposition:
- Package axi_lite_pkg:
  - resp_t: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - arb_state_t: the 5 states.
  - Width constants: AXI_ADDR_W=32, AXI_DATA_W=32, AXI_STRB_W=4.
- Sub-module rr_arbiter2:
  - Combinational 2-requester grant from req[1:0], last_grant and FIXED_PRIORITY.
  - Outputs gnt[1:0], one-hot or zero.
  - Reusable for future arbiters.

Test Plan:
1. Only m0 reads 0x8000_0000; slave arready on the 1st cycle, rvalid 2 cycles later with 0xDEADBEEF.
   -> s.arvalid rises 1 cycle after m0.arvalid; m0 gets rdata 0xDEADBEEF, rresp OKAY; m1 sees no activity.
2. m0 read and m1 write (0xA000_03F8, data 0x41, wmask 4'b0001) both asserted in the same cycle after reset.
   -> m0 is served first, then m1. The s.awaddr/wdata/wmask seen by s match m1's values exactly.
3. Both masters read continuously for 4 transactions, FIXED_PRIORITY=0.
   -> Grant order is m0,m1,m0,m1. With FIXED_PRIORITY=1 the order is m0,m0,m0,m0 while m0 keeps requesting.
4. m1 write with W presented 3 cycles before AW; then a repeat with AW and W in the same cycle.
   -> Exactly one AW and one W handshake each time. WR_RESP is entered only after both; bresp SLVERR (2'b10) is passed to m1.
5. Back-pressure: the slave holds arready=0 for 5 cycles, and m0.rready=0 for 3 cycles after rvalid.
   -> araddr and rdata stay stable; no extra handshakes; m1 gets no ready while m0 owns the port.
6. reset asserted in RD_DATA with rvalid pending.
   -> The next cycle is IDLE with all valids/readys 0; a new m1 read afterwards completes normally.
